// File: rtl/reg_wr_fifo.sv
// Captures committed register writes into a FWFT FIFO and presents them as an AXI-Stream master.
// Latency: a push into an empty FIFO shows TVALID one cycle later. There is no same-cycle bypass.
// Backpressure: TREADY low holds the head entry. Writes that arrive while full are dropped and set the sticky overflow flag.
//
// Ports:
//   S_AXI_ACLK, S_AXI_ARESETN  clock, synchronous active-low reset
//   wr_en/wr_adr/wr_dat/wr_wen one-cycle committed register write (word addr [9:3], data, strobes)
//   flush                      empties the FIFO; the overflow flag is kept
//   ovf_clr                    clears the sticky overflow flag
//   M_AXIS_TDATA/TUSER/TVALID/TREADY  head entry as stream; TUSER = {adr, wen}
//   level, full, overflow      status for the register slave
module reg_wr_fifo #(
  parameter int DEPTH = 16,  // power of two, 2..256
  parameter int AW    = 4    // log2(DEPTH)
) (
  input  logic          S_AXI_ACLK,
  input  logic          S_AXI_ARESETN,
  input  logic          wr_en,
  input  logic [6:0]    wr_adr,
  input  logic [63:0]   wr_dat,
  input  logic [7:0]    wr_wen,
  input  logic          flush,
  input  logic          ovf_clr,
  output logic [63:0]   M_AXIS_TDATA,
  output logic [14:0]   M_AXIS_TUSER,
  output logic          M_AXIS_TVALID,
  input  logic          M_AXIS_TREADY,
  output logic [AW:0]   level,
  output logic          full,
  output logic          overflow
);

  typedef struct packed {
    logic [6:0]  adr;
    logic [7:0]  wen;
    logic [63:0] dat;
  } entry_t;

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  // Storage is deliberately not reset; only pointers and level define validity.
  entry_t        mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q,  level_d;
  logic          ovf_q,    ovf_d;

  logic          full_s;
  logic          valid_s;
  logic          push;
  logic          pop;
  logic          drop;
  entry_t        wr_entry;
  entry_t        head;

  // Status comes from registered level only, so TREADY never reaches full combinationally.
  assign full_s  = (level_q == FULL_LVL);
  assign valid_s = (level_q != '0);

  assign wr_entry = '{adr: wr_adr, wen: wr_wen, dat: wr_dat};

  // Flush has priority: no push, no pop, and a write in that cycle does not count as dropped.
  assign push = wr_en & ~full_s & ~flush;
  assign pop  = valid_s & M_AXIS_TREADY & ~flush;
  assign drop = wr_en & full_s & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + (AW+1)'(1);
        2'b01:   level_d = level_q - (AW+1)'(1);
        default: level_d = level_q;
      endcase
    end

    // A drop in the same cycle as ovf_clr wins, so no drop event is lost.
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // A write into a slot beyond the read pointer is harmless even during reset.
  // Validity is decided by level_q, so the storage needs no reset gating.
  always_ff @(posedge S_AXI_ACLK) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  // First-word-fall-through: the head entry is visible as soon as it is stored.
  assign head = mem_q[rd_ptr_q];

  assign M_AXIS_TDATA  = head.dat;
  assign M_AXIS_TUSER  = {head.adr, head.wen};
  assign M_AXIS_TVALID = valid_s;
  assign level         = level_q;
  assign full          = full_s;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_reg_wr_fifo.sv
module tb_reg_wr_fifo;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          wr_en, flush, ovf_clr, tready;
  logic [6:0]    adr;
  logic [63:0]   dat;
  logic [7:0]    wen;
  logic [63:0]   tdata;
  logic [14:0]   tuser;
  logic          tvalid;
  logic [AW:0]   level;
  logic          full, overflow;

  always #5 clk = ~clk;

  reg_wr_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rstn),
    .wr_en(wr_en), .wr_adr(adr), .wr_dat(dat), .wr_wen(wen),
    .flush(flush), .ovf_clr(ovf_clr),
    .M_AXIS_TDATA(tdata), .M_AXIS_TUSER(tuser), .M_AXIS_TVALID(tvalid),
    .M_AXIS_TREADY(tready),
    .level(level), .full(full), .overflow(overflow)
  );

  // Reference model: queue of {adr, wen, dat} in arrival order plus the sticky flag.
  logic [78:0] q[$];
  bit          m_ovf;
  int          n_chk  = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("tvalid", 80'(tvalid), 80'(q.size() != 0));
    chk("level", 80'(level), 80'(q.size()));
    chk("full", 80'(full), 80'(q.size() == DEPTH));
    chk("overflow", 80'(overflow), 80'(m_ovf));
    if (q.size() != 0) begin
      chk("tdata", 80'(tdata), 80'(q[0][63:0]));
      chk("tuser", 80'(tuser), 80'(q[0][78:64]));
    end
  endtask

  // Apply one cycle of inputs, advance the model, then check #1 after the edge.
  task automatic step(input logic we, input logic [6:0] a, input logic [63:0] d,
                      input logic [7:0] w, input logic rdy, input logic fl, input logic clr);
    bit was_full, was_vld;
    wr_en = we; adr = a; dat = d; wen = w; tready = rdy; flush = fl; ovf_clr = clr;
    @(posedge clk);
    was_full = (q.size() == DEPTH);
    was_vld  = (q.size() != 0);
    if (fl) q.delete();
    else begin
      if (was_vld && rdy) void'(q.pop_front());
      if (we && !was_full) q.push_back({a, w, d});
    end
    if (!fl && we && was_full) m_ovf = 1'b1;
    else if (clr)              m_ovf = 1'b0;
    #1;
    wr_en = 1'b0; flush = 1'b0; ovf_clr = 1'b0;
    check_outputs();
  endtask

  task automatic wr(input logic [63:0] d, input logic rdy);
    step(1'b1, 7'($urandom), d, 8'($urandom), rdy, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 7'd0, 64'd0, 8'd0, rdy, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    rstn = 1'b0; wr_en = 1'b0; flush = 1'b0; ovf_clr = 1'b0; tready = 1'b1;
    repeat (n) @(posedge clk);
    q.delete();
    m_ovf = 1'b0;
    #1;
    check_outputs();
    rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [14:0] exp_u;
    bit          ovf_before;
    rstn = 1'b0; wr_en = 1'b0; flush = 1'b0; ovf_clr = 1'b0; tready = 1'b0;
    adr = '0; dat = '0; wen = '0;

    // Reset, then idle with TREADY high.
    do_reset(3);
    repeat (10) idle(1'b1);

    // Single write shows up one cycle later, then a pop empties the FIFO.
    step(1'b1, 7'h02, 64'h1122334455667788, 8'hFF, 1'b0, 1'b0, 1'b0);
    exp_u = {7'h02, 8'hFF};
    chk("t2_tdata", 80'(tdata), 80'(64'h1122334455667788));
    chk("t2_tuser", 80'(tuser), 80'(exp_u));
    chk("t2_level", 80'(level), 80'd1);
    idle(1'b1);
    chk("t2_empty", 80'(level), 80'd0);

    // Overfill by one, then drain in order. Pointers start offset, so the drain wraps.
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i <= 16; i++) wr(64'(i), 1'b0);
      chk("t3_full", 80'(full), 80'd1);
      chk("t3_ovf", 80'(overflow), 80'd1);
      chk("t3_level", 80'(level), 80'd16);
      for (int i = 0; i < 16; i++) begin
        chk("t3_order", 80'(tdata), 80'(i));
        idle(1'b1);
      end
      chk("t3_drained", 80'(tvalid), 80'd0);
      step(1'b0, 7'd0, 64'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    end

    // Simultaneous push and pop holds the level steady.
    for (int i = 0; i < 5; i++) wr(64'(200 + i), 1'b0);
    for (int i = 0; i < 20; i++) begin
      wr(64'(300 + i), 1'b1);
      chk("t4_level", 80'(level), 80'd5);
    end

    // A write while full with a pop in the same cycle is dropped.
    // Then check that ovf_clr is overridden by a drop in the same cycle.
    for (int i = 0; i < 11; i++) wr(64'(400 + i), 1'b0);
    chk("t5_full", 80'(full), 80'd1);
    wr(64'hDEAD, 1'b1);
    chk("t5_level", 80'(level), 80'd15);
    chk("t5_ovf_set", 80'(overflow), 80'd1);
    step(1'b0, 7'd0, 64'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    chk("t5_ovf_clr", 80'(overflow), 80'd0);
    wr(64'h55, 1'b0);
    step(1'b1, 7'h11, 64'hBEEF, 8'h0F, 1'b0, 1'b0, 1'b1);
    chk("t5_ovf_prio", 80'(overflow), 80'd1);

    // A flush discards a concurrent write and leaves the overflow flag alone.
    step(1'b0, 7'd0, 64'd0, 8'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) wr(64'(500 + i), 1'b0);
    chk("t6_level9", 80'(level), 80'd9);
    ovf_before = m_ovf;
    step(1'b1, 7'h33, 64'hCAFE, 8'hAA, 1'b0, 1'b1, 1'b0);
    chk("t6_level", 80'(level), 80'd0);
    chk("t6_tvalid", 80'(tvalid), 80'd0);
    chk("t6_ovf", 80'(overflow), 80'(ovf_before));

    // Random traffic with a reset asserted mid-stream.
    for (int c = 0; c < 400; c++) begin
      if (c == 200) do_reset(1);
      step(1'($urandom_range(0, 2) != 0), 7'($urandom), {$urandom, $urandom}, 8'($urandom),
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 39) == 0),
           1'($urandom_range(0, 15) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
